// File: rtl/risc32_pipe.sv
// risc32_pipe: 5-stage in-order MIPS-style core (IF/ID/EX/MEM/WB) with a unified
// word-addressed memory, an RAW interlock in ID and no forwarding.
module risc32_pipe #(
    parameter int MEM_WORDS = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    logic [31:0] mem  [0:MEM_WORDS-1];
    logic [31:0] regb [0:31];
    logic [31:0] pc, pc_d;
    logic        taken_branch;
    logic        halt_fetch_q, halt_fetch_d;

    logic        ifid_v_q, ifid_v_d;
    logic [31:0] ifid_ir_q, ifid_ir_d, ifid_pc_q, ifid_pc_d;

    logic        idex_v_q, idex_v_d, idex_wr_q, idex_wr_d;
    logic [5:0]  idex_op_q, idex_op_d;
    logic [4:0]  idex_dst_q, idex_dst_d;
    logic [31:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
    logic [31:0] idex_imm_q, idex_imm_d, idex_pc_q, idex_pc_d;

    logic        exmem_v_q, exmem_v_d, exmem_wr_q, exmem_wr_d;
    logic        exmem_lw_q, exmem_lw_d, exmem_sw_q, exmem_sw_d, exmem_hlt_q, exmem_hlt_d;
    logic [4:0]  exmem_dst_q, exmem_dst_d;
    logic [31:0] exmem_alu_q, exmem_alu_d, exmem_b_q, exmem_b_d;

    logic        memwb_v_q, memwb_v_d, memwb_wr_q, memwb_wr_d, memwb_hlt_q, memwb_hlt_d;
    logic [4:0]  memwb_dst_q, memwb_dst_d;
    logic [31:0] memwb_val_q, memwb_val_d;

    logic [5:0]  id_op_s;
    logic [4:0]  id_rs_s, id_rt_s, id_rd_s, id_dst_s;
    logic [31:0] id_imm_s;
    logic        id_wr_s, id_use_rt_s, id_stall_s, id_hlt_s;
    logic [31:0] ex_alu_s, ex_target_s;
    logic        ex_taken_s;
    logic [31:0] mem_rdata_s;

    function automatic logic dst_match(input logic v, input logic wr,
                                       input logic [4:0] dst, input logic [4:0] src);
        return v && wr && (src != 5'd0) && (dst == src);
    endfunction

    assign id_op_s  = ifid_ir_q[31:26];
    assign id_rs_s  = ifid_ir_q[25:21];
    assign id_rt_s  = ifid_ir_q[20:16];
    assign id_rd_s  = ifid_ir_q[15:11];
    assign id_imm_s = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};

    // Decode: destination register and which source fields the interlock must watch.
    always_comb begin
        id_wr_s     = 1'b0;
        id_dst_s    = 5'd0;
        id_use_rt_s = 1'b0;
        case (id_op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                id_wr_s     = 1'b1;
                id_dst_s    = id_rd_s;
                id_use_rt_s = 1'b1;
            end
            OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
                id_wr_s  = 1'b1;
                id_dst_s = id_rt_s;
            end
            OP_SW, OP_BNEQZ, OP_BEQZ: id_use_rt_s = 1'b1;
            default: id_wr_s = 1'b0;
        endcase
    end

    assign id_stall_s = ifid_v_q && (
        dst_match(idex_v_q,  idex_wr_q,  idex_dst_q,  id_rs_s) ||
        dst_match(exmem_v_q, exmem_wr_q, exmem_dst_q, id_rs_s) ||
        dst_match(memwb_v_q, memwb_wr_q, memwb_dst_q, id_rs_s) ||
        (id_use_rt_s && (
            dst_match(idex_v_q,  idex_wr_q,  idex_dst_q,  id_rt_s) ||
            dst_match(exmem_v_q, exmem_wr_q, exmem_dst_q, id_rt_s) ||
            dst_match(memwb_v_q, memwb_wr_q, memwb_dst_q, id_rt_s))));
    assign id_hlt_s = ifid_v_q && (id_op_s == OP_HLT);

    // Execute: ALU result and branch resolution.
    always_comb begin
        ex_alu_s   = 32'd0;
        ex_taken_s = 1'b0;
        case (idex_op_q)
            OP_ADD:  ex_alu_s = idex_a_q + idex_b_q;
            OP_SUB:  ex_alu_s = idex_a_q - idex_b_q;
            OP_AND:  ex_alu_s = idex_a_q & idex_b_q;
            OP_OR:   ex_alu_s = idex_a_q | idex_b_q;
            OP_SLT:  ex_alu_s = {31'd0, ($signed(idex_a_q) < $signed(idex_b_q))};
            OP_MUL:  ex_alu_s = idex_a_q * idex_b_q;
            OP_LW, OP_SW, OP_ADDI: ex_alu_s = idex_a_q + idex_imm_q;
            OP_SUBI: ex_alu_s = idex_a_q - idex_imm_q;
            OP_SLTI: ex_alu_s = {31'd0, ($signed(idex_a_q) < $signed(idex_imm_q))};
            OP_BEQZ:  ex_taken_s = idex_v_q && (idex_a_q == 32'd0);
            OP_BNEQZ: ex_taken_s = idex_v_q && (idex_a_q != 32'd0);
            default: ex_alu_s = 32'd0;
        endcase
    end

    assign ex_target_s = idex_pc_q + 32'd1 + idex_imm_q;
    assign mem_rdata_s = mem[exmem_alu_q[AW-1:0]];

    // Fetch and pipeline-latch next state; a taken branch outranks stall and halt.
    always_comb begin
        pc_d         = pc;
        halt_fetch_d = halt_fetch_q;
        ifid_v_d     = ifid_v_q;
        ifid_ir_d    = ifid_ir_q;
        ifid_pc_d    = ifid_pc_q;
        if (ex_taken_s) begin
            pc_d     = ex_target_s;
            ifid_v_d = 1'b0;
        end else if (id_stall_s) begin
            ifid_v_d = ifid_v_q;
        end else if (id_hlt_s) begin
            ifid_v_d     = 1'b0;
            halt_fetch_d = 1'b1;
        end else if (!halt_fetch_q) begin
            ifid_v_d  = 1'b1;
            ifid_ir_d = mem[pc[AW-1:0]];
            ifid_pc_d = pc;
            pc_d      = pc + 32'd1;
        end else begin
            ifid_v_d = 1'b0;
        end

        idex_v_d   = ifid_v_q && !ex_taken_s && !id_stall_s;
        idex_op_d  = id_op_s;
        idex_wr_d  = id_wr_s;
        idex_dst_d = id_dst_s;
        idex_a_d   = regb[id_rs_s];
        idex_b_d   = regb[id_rt_s];
        idex_imm_d = id_imm_s;
        idex_pc_d  = ifid_pc_q;

        exmem_v_d   = idex_v_q;
        exmem_wr_d  = idex_wr_q;
        exmem_dst_d = idex_dst_q;
        exmem_alu_d = ex_alu_s;
        exmem_b_d   = idex_b_q;
        exmem_lw_d  = (idex_op_q == OP_LW);
        exmem_sw_d  = (idex_op_q == OP_SW);
        exmem_hlt_d = (idex_op_q == OP_HLT);

        memwb_v_d   = exmem_v_q;
        memwb_wr_d  = exmem_wr_q;
        memwb_dst_d = exmem_dst_q;
        memwb_val_d = exmem_lw_q ? mem_rdata_s : exmem_alu_q;
        memwb_hlt_d = exmem_hlt_q;
    end

    // Pipeline state registers with synchronous reset to an all-bubble pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0;  halt_fetch_q <= 1'b0;  halted <= 1'b0;  taken_branch <= 1'b0;
            ifid_v_q <= 1'b0;  ifid_ir_q <= 32'd0;  ifid_pc_q <= 32'd0;
            idex_v_q <= 1'b0;  idex_op_q <= 6'd0;  idex_wr_q <= 1'b0;  idex_dst_q <= 5'd0;
            idex_a_q <= 32'd0; idex_b_q <= 32'd0;  idex_imm_q <= 32'd0; idex_pc_q <= 32'd0;
            exmem_v_q <= 1'b0; exmem_wr_q <= 1'b0; exmem_dst_q <= 5'd0; exmem_alu_q <= 32'd0;
            exmem_b_q <= 32'd0; exmem_lw_q <= 1'b0; exmem_sw_q <= 1'b0; exmem_hlt_q <= 1'b0;
            memwb_v_q <= 1'b0; memwb_wr_q <= 1'b0; memwb_dst_q <= 5'd0; memwb_val_q <= 32'd0;
            memwb_hlt_q <= 1'b0;
        end else begin
            pc <= pc_d;  halt_fetch_q <= halt_fetch_d;  taken_branch <= ex_taken_s;
            halted <= halted | (memwb_v_q & memwb_hlt_q);
            ifid_v_q <= ifid_v_d;  ifid_ir_q <= ifid_ir_d;  ifid_pc_q <= ifid_pc_d;
            idex_v_q <= idex_v_d;  idex_op_q <= idex_op_d;  idex_wr_q <= idex_wr_d;
            idex_dst_q <= idex_dst_d;  idex_a_q <= idex_a_d;  idex_b_q <= idex_b_d;
            idex_imm_q <= idex_imm_d;  idex_pc_q <= idex_pc_d;
            exmem_v_q <= exmem_v_d;  exmem_wr_q <= exmem_wr_d;  exmem_dst_q <= exmem_dst_d;
            exmem_alu_q <= exmem_alu_d;  exmem_b_q <= exmem_b_d;  exmem_lw_q <= exmem_lw_d;
            exmem_sw_q <= exmem_sw_d;  exmem_hlt_q <= exmem_hlt_d;
            memwb_v_q <= memwb_v_d;  memwb_wr_q <= memwb_wr_d;  memwb_dst_q <= memwb_dst_d;
            memwb_val_q <= memwb_val_d;  memwb_hlt_q <= memwb_hlt_d;
        end
    end

    // Store in MEM; the reset edge discards whatever store is in flight.
    always_ff @(posedge clk) begin
        if (!rst && exmem_v_q && exmem_sw_q)
            mem[exmem_alu_q[AW-1:0]] <= exmem_b_q;
    end

    // Register writeback in WB; R0 is never written.
    always_ff @(posedge clk) begin
        if (!rst && memwb_v_q && memwb_wr_q && (memwb_dst_q != 5'd0))
            regb[memwb_dst_q] <= memwb_val_q;
    end
endmodule

// File: tb/tb_risc32_pipe.sv
// Scoreboard bench for risc32_pipe: directed programs push expected architectural
// state; a monitor checks it when halted rises or at an explicit snapshot point.
module tb_risc32_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    risc32_pipe #(.MEM_WORDS(1024)) dut (.clk(clk), .rst(rst), .halted(halted));

    always #5 clk = ~clk;

    localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_HALT = 3, K_TAKEN = 4, K_CYC = 5;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb_q[$];
    int   rd_ptr    = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   snap_req  = 0;
    int   snap_seen = 0;
    int   taken_cnt = 0;
    int   cyc_cnt   = 0;
    int   wd        = 0;
    logic halted_prev = 1'b0;

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_REG:   return dut.regb[idx];
            K_MEM:   return dut.mem[idx];
            K_PC:    return dut.pc;
            K_HALT:  return {31'd0, dut.halted};
            K_TAKEN: return taken_cnt;
            default: return cyc_cnt;
        endcase
    endfunction

    // Monitor: drains the scoreboard when the core halts or a snapshot is requested.
    initial begin
        forever begin
            @(negedge clk);
            if ((halted === 1'b1 && halted_prev !== 1'b1) || (snap_req != snap_seen)) begin
                snap_seen = snap_req;
                while (rd_ptr < sb_q.size()) begin
                    exp_t e;
                    logic [31:0] act;
                    e   = sb_q[rd_ptr];
                    act = actual(e.kind, e.idx);
                    checks++;
                    if ($isunknown(act) || act < e.lo || act > e.hi) begin
                        errors++;
                        $display("FAIL %s: got %0d (0x%08h), want %0d..%0d", e.name, act, act, e.lo, e.hi);
                    end
                    rd_ptr++;
                end
                wd = 0;
            end else if (rd_ptr < sb_q.size()) begin
                wd++;
                if (wd > 400) begin
                    while (rd_ptr < sb_q.size()) begin
                        checks++;
                        errors++;
                        $display("FAIL %s: timeout, no halt within bound", sb_q[rd_ptr].name);
                        rd_ptr++;
                    end
                    wd = 0;
                end
            end else begin
                wd = 0;
            end
            if (rst) begin
                taken_cnt = 0;
                cyc_cnt   = 0;
            end else begin
                if (taken_branch_s()) taken_cnt++;
                if (halted !== 1'b1) cyc_cnt++;
            end
            halted_prev = halted;
        end
    end

    function automatic logic taken_branch_s();
        return (dut.taken_branch === 1'b1);
    endfunction

    task automatic expect_val(input string nm, input int kind, input int idx,
                              input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        e.name = nm; e.kind = kind; e.idx = idx; e.lo = lo; e.hi = hi;
        sb_q.push_back(e);
    endtask

    task automatic exp_eq(input string nm, input int kind, input int idx, input logic [31:0] v);
        expect_val(nm, kind, idx, v, v);
    endtask

    // Assert reset for one edge, clear memory and R0, leave rst high.
    task automatic begin_test();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) dut.mem[i] = 32'd0;
        dut.regb[0] = 32'd0;
    endtask

    task automatic wait_drain();
        while (rd_ptr < sb_q.size()) @(negedge clk);
    endtask

    task automatic release_run();
        rst = 1'b0;
        wait_drain();
    endtask

    task automatic snap();
        snap_req++;
        wait_drain();
    endtask

    task automatic load_loop();
        dut.mem[0] = 32'h28010003;
        dut.mem[1] = 32'h28020000;
        dut.mem[2] = 32'h28420005;
        dut.mem[3] = 32'h2C210001;
        dut.mem[4] = 32'h3420FFFD;
        dut.mem[5] = 32'hFC000000;
    endtask

    initial begin
        // Reset state
        begin_test();
        exp_eq("rst_pc", K_PC, 0, 32'd0);
        exp_eq("rst_halted", K_HALT, 0, 32'd0);
        snap();

        // Independent ALU ops padded with dummy ORs
        begin_test();
        dut.mem[0] = 32'h28010001; dut.mem[1] = 32'h28020010; dut.mem[2] = 32'h28030011;
        dut.mem[3] = 32'h0ce77800; dut.mem[4] = 32'h0ce77800; dut.mem[5] = 32'h00222000;
        dut.mem[6] = 32'h0ce77800; dut.mem[7] = 32'h00822800; dut.mem[8] = 32'hfc000000;
        dut.regb[7] = 32'h00007777;
        exp_eq("p1_r1", K_REG, 1, 32'd1);
        exp_eq("p1_r2", K_REG, 2, 32'd16);
        exp_eq("p1_r3", K_REG, 3, 32'd17);
        exp_eq("p1_r4", K_REG, 4, 32'd17);
        exp_eq("p1_r5", K_REG, 5, 32'd33);
        exp_eq("p1_r7", K_REG, 7, 32'h00007777);
        exp_eq("p1_halted", K_HALT, 0, 32'd1);
        release_run();

        // Same program relying on the interlock
        begin_test();
        dut.mem[0] = 32'h28010001; dut.mem[1] = 32'h28020010; dut.mem[2] = 32'h28030011;
        dut.mem[3] = 32'h00222000; dut.mem[4] = 32'h00822800; dut.mem[5] = 32'hfc000000;
        exp_eq("p2_r1", K_REG, 1, 32'd1);
        exp_eq("p2_r2", K_REG, 2, 32'd16);
        exp_eq("p2_r3", K_REG, 3, 32'd17);
        exp_eq("p2_r4", K_REG, 4, 32'd17);
        exp_eq("p2_r5", K_REG, 5, 32'd33);
        expect_val("p2_cycles", K_CYC, 0, 32'd11, 32'd40);
        release_run();

        // Load / add / store
        begin_test();
        dut.mem[0] = 32'h20220000; dut.mem[1] = 32'h2842002D;
        dut.mem[2] = 32'h24220001; dut.mem[3] = 32'hFC000000;
        dut.mem[120] = 32'd85;
        dut.regb[1]  = 32'd120;
        exp_eq("ls_mem121", K_MEM, 121, 32'd130);
        exp_eq("ls_r2", K_REG, 2, 32'd130);
        release_run();

        // Counted loop with backward branch
        begin_test();
        load_loop();
        exp_eq("loop_r2", K_REG, 2, 32'd15);
        exp_eq("loop_r1", K_REG, 1, 32'd0);
        exp_eq("loop_taken", K_TAKEN, 0, 32'd2);
        exp_eq("loop_halted", K_HALT, 0, 32'd1);
        release_run();

        // Taken branch flushes its shadow; not-taken falls through
        begin_test();
        dut.mem[0] = 32'h38000002; dut.mem[1] = 32'h28090063; dut.mem[2] = 32'h28090064;
        dut.mem[3] = 32'h34000002; dut.mem[4] = 32'h280A0007; dut.mem[5] = 32'hFC000000;
        dut.regb[9]  = 32'h00000999;
        dut.regb[10] = 32'h00001010;
        exp_eq("br_r9", K_REG, 9, 32'h00000999);
        exp_eq("br_r10", K_REG, 10, 32'd7);
        exp_eq("br_taken", K_TAKEN, 0, 32'd1);
        release_run();

        // Reset mid-loop: first reset edge is the 9th edge after release
        begin_test();
        load_loop();
        dut.regb[1] = 32'h0000AAAA;
        dut.regb[2] = 32'h0000AAAA;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        exp_eq("mid_pc", K_PC, 0, 32'd0);
        exp_eq("mid_halted", K_HALT, 0, 32'd0);
        snap();
        repeat (2) @(posedge clk);
        #1;
        exp_eq("mid_r1", K_REG, 1, 32'd3);
        exp_eq("mid_r2", K_REG, 2, 32'd0);
        exp_eq("mid_pc_held", K_PC, 0, 32'd0);
        snap();
        @(posedge clk);
        #1;
        exp_eq("rerun_r2", K_REG, 2, 32'd15);
        exp_eq("rerun_r1", K_REG, 1, 32'd0);
        exp_eq("rerun_taken", K_TAKEN, 0, 32'd2);
        exp_eq("rerun_halted", K_HALT, 0, 32'd1);
        release_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "global timeout");
    end
endmodule
